// File: rtl/cps_gfx_rom_fetch.sv
// Graphics ROM fetch stage behind cps_a: one req/ack read per tile slot, with one pending slot.
// Each fetched planar word is converted to chunky 4bpp pixels and tagged with its layer.
module cps_gfx_rom_fetch #(
  parameter int AW      = 23,
  parameter int DW      = 64,
  parameter int TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          HBLANK_N,
  input  logic          SLOT_STB,
  input  logic [AW-1:0] ROMA,
  input  logic          FLIP,
  output logic          ROM_REQ,
  output logic [AW-1:0] ROM_ADDR,
  input  logic          ROM_ACK,
  input  logic [DW-1:0] ROM_DATA,
  output logic          OUT_VALID,
  output logic [2:0]    OUT_LAYER,
  output logic [DW-1:0] OUT_PIX,
  output logic          BUSY,
  output logic          OVERRUN,
  output logic          TIMEOUT_ERR
);

  localparam int NPIX = DW / 4;
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, CAPT} state_t;

  state_t          state, state_nxt;
  logic [7:0]      tmo_cnt;
  logic            cur_flip;
  logic [DW-1:0]   data_q;
  logic            hblank_q;
  logic            pend_valid, pend_flip;
  logic [AW-1:0]   pend_addr;

  logic            pend_live, start, start_flip, ack_take, abort, emit;
  logic [AW-1:0]   start_addr;
  logic            pend_valid_nxt, pend_flip_nxt, overrun_nxt;
  logic [AW-1:0]   pend_addr_nxt;
  logic [DW-1:0]   pix_conv;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // A falling HBLANK_N kills the pending slot before it can be issued or block a new strobe.
  assign pend_live = pend_valid & ~(hblank_q & ~HBLANK_N);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend_live || SLOT_STB) state_nxt = REQ;
      REQ:     if (ROM_ACK) state_nxt = CAPT;
               else if (tmo_cnt == TMO) state_nxt = IDLE;
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start          = (state == IDLE) && (pend_live || SLOT_STB);
    start_addr     = pend_live ? pend_addr : ROMA;
    start_flip     = pend_live ? pend_flip : FLIP;
    ack_take       = (state == REQ) && ROM_ACK;
    abort          = (state == REQ) && !ROM_ACK && (tmo_cnt == TMO);
    emit           = (state == CAPT);
    pend_valid_nxt = pend_live;
    pend_addr_nxt  = pend_addr;
    pend_flip_nxt  = pend_flip;
    overrun_nxt    = 1'b0;
    if (state == IDLE) begin
      if (pend_live && SLOT_STB) begin
        pend_addr_nxt = ROMA;
        pend_flip_nxt = FLIP;
      end else begin
        pend_valid_nxt = 1'b0;
      end
    end else if (SLOT_STB) begin
      if (pend_live) begin
        overrun_nxt = 1'b1;
      end else begin
        pend_valid_nxt = 1'b1;
        pend_addr_nxt  = ROMA;
        pend_flip_nxt  = FLIP;
      end
    end
  end

  always_comb begin
    pix_conv = '0;
    for (int n = 0; n < NPIX; n++)
      for (int p = 0; p < 4; p++)
        pix_conv[4*n+p] = cur_flip ? data_q[NPIX*p + NPIX-1-n] : data_q[NPIX*p + n];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ROM_REQ     <= 1'b0;
      ROM_ADDR    <= '0;
      cur_flip    <= 1'b0;
      tmo_cnt     <= '0;
      data_q      <= '0;
      hblank_q    <= 1'b0;
      pend_valid  <= 1'b0;
      pend_addr   <= '0;
      pend_flip   <= 1'b0;
      OUT_VALID   <= 1'b0;
      OUT_LAYER   <= '0;
      OUT_PIX     <= '0;
      OVERRUN     <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      hblank_q   <= HBLANK_N;
      pend_valid <= pend_valid_nxt;
      pend_addr  <= pend_addr_nxt;
      pend_flip  <= pend_flip_nxt;
      if (start) begin
        ROM_REQ  <= 1'b1;
        ROM_ADDR <= start_addr;
        cur_flip <= start_flip;
        tmo_cnt  <= '0;
      end else if (state == REQ) begin
        if (ack_take || abort) ROM_REQ <= 1'b0;
        if (tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (ack_take) data_q <= ROM_DATA;
      OUT_VALID <= emit;
      if (emit) begin
        OUT_LAYER <= ROM_ADDR[AW-1:AW-3];
        OUT_PIX   <= pix_conv;
      end
      OVERRUN     <= overrun_nxt;
      TIMEOUT_ERR <= abort;
    end
  end

  assign BUSY = (state != IDLE);

endmodule
